ram_fifo_ctrl: RTL and testbench

Controller that turns the 6-bit x 8-entry synchronous RAM into a first-word-fall-through FIFO with valid/ready handshakes on both sides.
- It drives the RAM's write and read ports.
- It absorbs the RAM's 1-cycle registered read latency with a 2-entry output buffer, so the FIFO sustains one pop per cycle.
- It sits between a producer stage and a consumer stage, with the RAM instantiated alongside it.

---
 rtl/ram_fifo_ctrl.sv | 128 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: drives a registered-read RAM as a first-word-fall-through FIFO.
// Words are written into the RAM. They are read back into a two-entry output
// buffer. The buffer hides the one-cycle RAM read latency, so one word can pop
// every cycle.
`timescale 1ns/1ps

module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 6,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int RAM_AW     = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [3:0]            level,
    output logic                  ram_write_en,
    output logic [RAM_AW-1:0]     ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  ram_read_en,
    output logic [RAM_AW-1:0]     ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);

    localparam logic [PTR_WIDTH:0] RAM_FULL = (PTR_WIDTH+1)'(DEPTH);

    // Registered state
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH:0]    ram_cnt;   // words in the RAM not yet read out
    logic                  rd_pend;   // read issued last cycle, data on ram_read_data now
    logic [1:0]            obuf_cnt;
    logic [DATA_WIDTH-1:0] obuf_head;
    logic [DATA_WIDTH-1:0] obuf_tail;
    logic [3:0]            level_q;

    // Per-cycle events and next-state values
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  capture;
    logic [PTR_WIDTH:0]    ram_cnt_nx;
    logic [1:0]            obuf_cnt_nx;
    logic [3:0]            level_nx;
    logic [2:0]            obuf_after;

    // Handshakes, RAM strobes and next counts; all outputs are forced low while in reset
    always_comb begin
        in_ready       = rst_n && (ram_cnt != RAM_FULL);
        out_valid      = rst_n && (obuf_cnt != 2'd0);
        out_data       = out_valid ? obuf_head : '0;
        level          = rst_n ? level_q : 4'd0;

        push           = in_valid && in_ready;
        pop            = out_valid && out_ready;
        capture        = rd_pend;

        // A read may only start if the word it returns will have a buffer slot.
        // That slot may be one freed by this cycle's pop.
        obuf_after     = 3'(obuf_cnt) + 3'(rd_pend);
        issue          = rst_n && (ram_cnt != '0) && (obuf_after < (3'd2 + 3'(pop)));

        ram_write_en   = push;
        ram_write_addr = rst_n ? RAM_AW'(wr_ptr) : '0;
        ram_write_data = rst_n ? in_data : '0;
        ram_read_en    = issue;
        ram_read_addr  = rst_n ? RAM_AW'(rd_ptr) : '0;

        ram_cnt_nx     = ram_cnt + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(issue);
        obuf_cnt_nx    = obuf_cnt + 2'(capture) - 2'(pop);
        level_nx       = 4'(ram_cnt_nx) + 4'(issue) + 4'(obuf_cnt_nx);
    end

    // Pointer, counter and output-buffer update; reset discards everything, including in-flight read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            rd_pend   <= 1'b0;
            obuf_cnt  <= 2'd0;
            obuf_head <= '0;
            obuf_tail <= '0;
            level_q   <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            ram_cnt  <= ram_cnt_nx;
            rd_pend  <= issue;
            obuf_cnt <= obuf_cnt_nx;
            level_q  <= level_nx;

            // The head always holds the oldest word; the tail is only used when two are held
            case ({capture, pop})
                2'b11: begin
                    if (obuf_cnt == 2'd2) begin
                        obuf_head <= obuf_tail;
                        obuf_tail <= ram_read_data;
                    end else begin
                        obuf_head <= ram_read_data;
                    end
                end
                2'b10: begin
                    if (obuf_cnt == 2'd0) begin
                        obuf_head <= ram_read_data;
                    end else begin
                        obuf_tail <= ram_read_data;
                    end
                end
                2'b01: begin
                    obuf_head <= obuf_tail;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed bench for ram_fifo_ctrl with a behavioural registered-read RAM.
`timescale 1ns/1ps

module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_data;
    logic [3:0] level;
    logic       ram_write_en;
    logic [5:0] ram_write_addr;
    logic [5:0] ram_write_data;
    logic       ram_read_en;
    logic [5:0] ram_read_addr;
    logic [5:0] ram_read_data = '0;

    logic [5:0] mem [64];

    int n_tests = 0;
    int n_fail  = 0;
    int sent, got, popped, first_cyc, last_cyc, cyc;
    logic [5:0] q [$];

    always #5 clk = ~clk;

    ram_fifo_ctrl #(
        .DATA_WIDTH(6), .DEPTH(8), .PTR_WIDTH(3), .RAM_AW(6)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level),
        .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
        .ram_read_en(ram_read_en), .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data)
    );

    // Registered-read RAM: data appears the cycle after the read strobe, zero otherwise
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
        ram_read_data <= ram_read_en ? mem[ram_read_addr] : 6'd0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset, then idle
        rst_n = 1'b0; in_valid = 1'b1; in_data = 6'h3F; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("t1_rst_in_ready", in_ready, 0);
        check("t1_rst_we", ram_write_en, 0);
        check("t1_rst_re", ram_read_en, 0);
        check("t1_rst_out_valid", out_valid, 0);
        check("t1_rst_out_data", out_data, 0);
        check("t1_rst_level", level, 0);
        check("t1_rst_waddr", ram_write_addr, 0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check("t1_idle_out_valid", out_valid, 0);
            check("t1_idle_in_ready", in_ready, 1);
            check("t1_idle_level", level, 0);
            check("t1_idle_we", ram_write_en, 0);
            check("t1_idle_re", ram_read_en, 0);
        end

        // 2: single word through an empty FIFO
        @(negedge clk); in_valid = 1'b1; in_data = 6'h15; out_ready = 1'b1; #1;
        check("t2_we", ram_write_en, 1);
        check("t2_waddr", ram_write_addr, 0);
        check("t2_wdata", ram_write_data, 6'h15);
        @(negedge clk); in_valid = 1'b0; #1;
        check("t2_re", ram_read_en, 1);
        check("t2_raddr", ram_read_addr, 0);
        check("t2_level_a", level, 1);
        check("t2_valid_early", out_valid, 0);
        @(negedge clk); #1;
        check("t2_valid_inflight", out_valid, 0);
        check("t2_level_b", level, 1);
        @(negedge clk); #1;
        check("t2_valid", out_valid, 1);
        check("t2_data", out_data, 6'h15);
        @(negedge clk); #1;
        check("t2_valid_after", out_valid, 0);
        check("t2_level_after", level, 0);

        // 3: back-pressure fill to DEPTH+2, then drain in order
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 6'(i); #1;
            check("t3_fill_in_ready", in_ready, 1);
        end
        @(negedge clk); in_valid = 1'b1; in_data = 6'h3F; #1;
        check("t3_full_in_ready", in_ready, 0);
        check("t3_full_we", ram_write_en, 0);
        check("t3_full_level", level, 10);
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            #1;
            check("t3_pop_valid", out_valid, 1);
            check("t3_pop_data", out_data, i);
            if (i == 1) check("t3_in_ready_still_low", in_ready, 0);
            if (i == 2) check("t3_in_ready_rises", in_ready, 1);
            @(negedge clk);
        end
        #1;
        check("t3_empty_valid", out_valid, 0);
        check("t3_empty_level", level, 0);

        // 4: streaming 64 words, one push and one pop per cycle
        sent = 0; got = 0; first_cyc = -1; last_cyc = 0; cyc = 0;
        out_ready = 1'b1;
        while (got < 64 && cyc < 300) begin
            @(negedge clk);
            in_valid = (sent < 64);
            in_data  = sent[5:0];
            #1;
            if (out_valid) begin
                check("t4_data", out_data, got);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            check("t4_level_le3", level <= 4'd3, 1);
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        check("t4_count", got, 64);
        check("t4_no_bubble", last_cyc - first_cyc + 1, 64);
        @(negedge clk); in_valid = 1'b0; #1;
        check("t4_end_level", level, 0);

        // 5: random traffic on both sides against a queue model
        q.delete(); sent = 0; popped = 0; cyc = 0;
        while (popped < 1000 && cyc < 20000) begin
            @(negedge clk);
            in_valid  = (sent < 1000) && ($urandom_range(0, 99) < 60);
            in_data   = 6'($urandom_range(0, 63));
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            check("t5_level", level, q.size());
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("t5_underflow", q.size(), 1);
                else check("t5_data", out_data, q.pop_front());
                popped++;
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
            end
            cyc++;
        end
        check("t5_sent", sent, 1000);
        check("t5_popped", popped, 1000);
        check("t5_queue_empty", q.size(), 0);
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; #1;
        check("t5_end_level", level, 0);
        check("t5_end_valid", out_valid, 0);

        // 6: reset with level 6 and a read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 6'(6'h30 + i); #1;
            check("t6_fill_in_ready", in_ready, 1);
        end
        @(negedge clk); in_valid = 1'b1; in_data = 6'h36; out_ready = 1'b1; #1;
        check("t6_pre_level", level, 6);
        check("t6_pre_head", out_data, 6'h30);
        check("t6_pre_re", ram_read_en, 1);
        @(negedge clk); rst_n = 1'b0; in_valid = 1'b1; in_data = 6'h3F; out_ready = 1'b0; #1;
        check("t6_inflight_data", ram_read_data, 6'h32);
        check("t6_rst_level", level, 0);
        check("t6_rst_in_ready", in_ready, 0);
        check("t6_rst_we", ram_write_en, 0);
        check("t6_rst_re", ram_read_en, 0);
        check("t6_rst_valid", out_valid, 0);
        @(negedge clk); rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; #1;
        check("t6_post_valid", out_valid, 0);
        check("t6_post_level", level, 0);
        check("t6_post_in_ready", in_ready, 1);
        @(negedge clk); #1;
        check("t6_no_stale_valid", out_valid, 0);
        check("t6_no_stale_level", level, 0);
        @(negedge clk); in_valid = 1'b1; in_data = 6'h2A; #1;
        check("t6_fresh_we", ram_write_en, 1);
        check("t6_fresh_waddr", ram_write_addr, 0);
        @(negedge clk); in_valid = 1'b0; #1;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("t6_fresh_valid", out_valid, 1);
        check("t6_fresh_data", out_data, 6'h2A);
        @(negedge clk); #1;
        check("t6_final_valid", out_valid, 0);
        check("t6_final_level", level, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
